arashi_dispatch: RTL



---
 rtl/arashi_pkg.sv | 17 +
 rtl/arashi_thread_fifo.sv | 59 +++++
 rtl/arashi_dispatch.sv | 59 +++++
 3 files changed

// File: rtl/arashi_pkg.sv
// Shared definitions for the arashi thread fan-out/fan-in path.
package arashi_pkg;

  // Default thread-count geometry shared with the merge-side cache/arbiter.
  localparam int THREAD_NUM_WIDTH_DEF = 2;

  // Thread count from its log2 width.
  function automatic int thread_num(input int width);
    return 1 << width;
  endfunction

  localparam int THREAD_NUM_DEF = thread_num(THREAD_NUM_WIDTH_DEF);

  // Thread id at the default geometry.
  typedef logic [THREAD_NUM_WIDTH_DEF-1:0] thread_id_t;

endpackage

// File: rtl/arashi_thread_fifo.sv
// Per-thread show-ahead FIFO: the head entry is always presented on data_out.
module arashi_thread_fifo
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_ena,
  input  logic                  r_ena,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  avail,
  output logic                  full,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   count;
  logic                   push;
  logic                   pop;

  assign full      = (count == (DEPTH_WIDTH+1)'(DEPTH));
  assign avail     = (count != '0);
  // A push onto a full FIFO is dropped; the top never issues one anyway.
  assign push      = w_ena && !full;
  // A pop on an empty FIFO is ignored and only reported.
  assign pop       = r_ena && avail;
  assign underflow = r_ena && !avail;
  assign data_out  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/arashi_dispatch.sv
// Single-stream to multi-thread distributor: steers tagged words into per-thread FIFOs.
module arashi_dispatch
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int DEPTH_WIDTH      = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [THREAD_NUM_WIDTH-1:0]                 in_thread_id,
  input  logic [DATA_WIDTH-1:0]                       data_in,
  output logic                                        in_ready,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]            r_ena,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]            avail,
  output logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0] data_out,
  output logic                                        idle,
  output logic                                        underflow_err
);

  localparam int THREAD_NUM = thread_num(THREAD_NUM_WIDTH);

  logic [THREAD_NUM-1:0] full;
  logic [THREAD_NUM-1:0] w_ena;
  logic [THREAD_NUM-1:0] underflow;
  logic                  push_ok;

  // Ready depends only on the selected thread's registered fullness, never on r_ena.
  assign in_ready = !full[in_thread_id] && !rst;
  assign push_ok  = in_valid && in_ready;
  assign idle     = ~|avail;

  for (genvar i = 0; i < THREAD_NUM; i++) begin : g_thr
    assign w_ena[i] = push_ok && (in_thread_id == THREAD_NUM_WIDTH'(i));

    arashi_thread_fifo #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .w_ena     (w_ena[i]),
      .r_ena     (r_ena[i]),
      .data_in   (data_in),
      .data_out  (data_out[DATA_WIDTH*i +: DATA_WIDTH]),
      .avail     (avail[i]),
      .full      (full[i]),
      .underflow (underflow[i])
    );
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)             underflow_err <= 1'b0;
    else if (|underflow) underflow_err <= 1'b1;
  end

endmodule
